// File: rtl/ram_multi_read_port_clr.sv
// Multi-read-port synchronous RAM with byte-lane writes, selectable
// read-during-write behaviour and a sweep engine that clears every word.

module ram_read_port #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  accept,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= accept & en;
      if (accept & en) data <= word;
    end
  end
endmodule

module ram_multi_read_port_clr #(
  parameter int                          DATA_WIDTH  = 16,
  parameter int                          LANE_WIDTH  = 8,
  parameter int                          ADDR_WIDTH  = 8,
  parameter int                          MEM_SIZE    = 256,
  parameter int                          READ_PORTS  = 2,
  parameter int                          WRITE_FIRST = 1,
  parameter logic [DATA_WIDTH-1:0]       CLEAR_VALUE = '0,
  parameter int                          LANES       = DATA_WIDTH / LANE_WIDTH
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic                             iClear,
  output logic                             oBusy,
  input  logic                             iWriteEnable,
  input  logic [ADDR_WIDTH-1:0]            iWriteAddress,
  input  logic [LANES-1:0]                 iByteEnable,
  input  logic [DATA_WIDTH-1:0]            iDataIn,
  input  logic [READ_PORTS-1:0]            iReadEnable,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] iReadAddress,
  output logic [READ_PORTS*DATA_WIDTH-1:0] oDataOut,
  output logic [READ_PORTS-1:0]            oDataValid
);
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(MEM_SIZE - 1);

  typedef enum logic {CLEAR, READY} state_t;
  state_t state, next_state;

  logic [ADDR_WIDTH:0]   clr_addr;
  logic [DATA_WIDTH-1:0] ram [0:MEM_SIZE-1];
  logic [DATA_WIDTH-1:0] merged;
  logic                  accept, wr_ok;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} <= LAST;
  endfunction

  assign oBusy  = (state == CLEAR);
  // An iClear edge in READY already belongs to the clear: no user traffic.
  assign accept = (state == READY) && !iClear;
  assign wr_ok  = accept && iWriteEnable && in_range(iWriteAddress);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= CLEAR;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      CLEAR: if (clr_addr == LAST && !iClear) next_state = READY;
      READY: if (iClear) next_state = CLEAR;
      default: next_state = CLEAR;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                         clr_addr <= '0;
    else if (iClear)                   clr_addr <= '0;
    else if (state == CLEAR)           clr_addr <= clr_addr + 1'b1;
  end

  // Storage has no reset; the sweep is the only initialiser.
  always_ff @(posedge Clock) begin
    if (state == CLEAR) begin
      ram[clr_addr[ADDR_WIDTH-1:0]] <= CLEAR_VALUE;
    end else if (wr_ok) begin
      for (int k = 0; k < LANES; k++)
        if (iByteEnable[k])
          ram[iWriteAddress][k*LANE_WIDTH +: LANE_WIDTH] <= iDataIn[k*LANE_WIDTH +: LANE_WIDTH];
    end
  end

  // Word as it will look after this edge's write, for write-first bypass.
  always_comb begin
    merged = ram[iWriteAddress];
    for (int k = 0; k < LANES; k++)
      if (iByteEnable[k])
        merged[k*LANE_WIDTH +: LANE_WIDTH] = iDataIn[k*LANE_WIDTH +: LANE_WIDTH];
  end

  genvar p;
  generate
    for (p = 0; p < READ_PORTS; p++) begin : g_port
      logic [ADDR_WIDTH-1:0] ra;
      logic [DATA_WIDTH-1:0] word;
      logic                  hit;

      assign ra   = iReadAddress[p*ADDR_WIDTH +: ADDR_WIDTH];
      assign hit  = (WRITE_FIRST != 0) && wr_ok && (ra == iWriteAddress);
      assign word = !in_range(ra) ? CLEAR_VALUE : (hit ? merged : ram[ra]);

      ram_read_port #(.DATA_WIDTH(DATA_WIDTH)) u_port (
        .clk   (Clock),
        .rst   (Reset),
        .accept(accept),
        .en    (iReadEnable[p]),
        .word  (word),
        .data  (oDataOut[p*DATA_WIDTH +: DATA_WIDTH]),
        .valid (oDataValid[p])
      );
    end
  endgenerate
endmodule

// File: tb/tb_ram_multi_read_port_clr.sv
// Directed bench: a write-first and a read-first instance share all inputs;
// expectations are hand-computed constants.

module tb_ram_multi_read_port_clr;
  localparam int AW = 9;
  localparam logic [15:0] CV = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        we  = 1'b0;
  logic [8:0]  wa  = '0;
  logic [1:0]  be  = '0;
  logic [15:0] din = '0;
  logic [1:0]  ren = '0;
  logic [17:0] ra  = '0;
  logic        busy_wf, busy_rf;
  logic [31:0] dout_wf, dout_rf;
  logic [1:0]  vld_wf, vld_rf;

  int checks = 0;
  int errors = 0;
  int cnt;

  always #5 clk = ~clk;

  ram_multi_read_port_clr #(
    .DATA_WIDTH(16), .LANE_WIDTH(8), .ADDR_WIDTH(AW), .MEM_SIZE(256),
    .READ_PORTS(2), .WRITE_FIRST(1), .CLEAR_VALUE(CV)
  ) u_wf (
    .Clock(clk), .Reset(rst), .iClear(clr), .oBusy(busy_wf),
    .iWriteEnable(we), .iWriteAddress(wa), .iByteEnable(be), .iDataIn(din),
    .iReadEnable(ren), .iReadAddress(ra), .oDataOut(dout_wf), .oDataValid(vld_wf)
  );

  ram_multi_read_port_clr #(
    .DATA_WIDTH(16), .LANE_WIDTH(8), .ADDR_WIDTH(AW), .MEM_SIZE(256),
    .READ_PORTS(2), .WRITE_FIRST(0), .CLEAR_VALUE(CV)
  ) u_rf (
    .Clock(clk), .Reset(rst), .iClear(clr), .oBusy(busy_rf),
    .iWriteEnable(we), .iWriteAddress(wa), .iByteEnable(be), .iDataIn(din),
    .iReadEnable(ren), .iReadAddress(ra), .oDataOut(dout_rf), .oDataValid(vld_rf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] en, input logic [8:0] a1, input logic [8:0] a0);
    ren = en;
    ra  = {a1, a0};
  endtask

  task automatic wr(input logic e, input logic [8:0] a, input logic [1:0] b, input logic [15:0] d);
    we = e; wa = a; be = b; din = d;
  endtask

  // Counts edges until the write-first instance drops busy; both must agree.
  task automatic count_busy(input string tag, input logic chk_vld);
    cnt = 0;
    do begin
      tick();
      cnt++;
      if (chk_vld) check({tag, "_vld"}, {30'd0, vld_wf}, 32'd0);
    end while (busy_wf && cnt < 300);
    check(tag, cnt, 256);
    check({tag, "_rf"}, {31'd0, busy_rf}, 32'd0);
  endtask

  initial begin
    #1;
    check("rst_busy", {30'd0, busy_wf, busy_rf}, 32'h3);
    check("rst_dout", dout_wf, 32'h0);
    check("rst_vld",  {28'd0, vld_wf, vld_rf}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    count_busy("sweep_len", 1'b0);

    rd(2'b11, 9'd128, 9'd0);
    tick();
    check("clr_rd_0_128", dout_wf, {CV, CV});
    check("clr_rd_vld",   {30'd0, vld_wf}, 32'h3);
    rd(2'b11, 9'd255, 9'd255);
    tick();
    check("clr_rd_255", dout_rf, {CV, CV});

    // Partial-lane write over an all-ones word.
    rd(2'b00, 9'd0, 9'd0);
    wr(1'b1, 9'd7, 2'b11, 16'hFFFF);
    tick();
    wr(1'b1, 9'd7, 2'b01, 16'h1234);
    tick();
    wr(1'b0, 9'd0, 2'b00, 16'h0);
    rd(2'b01, 9'd0, 9'd7);
    tick();
    check("lane_merge", dout_wf[15:0], 16'hFF34);
    check("lane_vld",   {30'd0, vld_wf}, 32'h1);

    // Collision on addr 3, port 1 only reading.
    wr(1'b1, 9'd3, 2'b11, 16'hFFFF);
    rd(2'b00, 9'd0, 9'd0);
    tick();
    wr(1'b1, 9'd3, 2'b11, 16'hBEEF);
    rd(2'b10, 9'd3, 9'd0);
    tick();
    check("coll_wf",   dout_wf[31:16], 16'hBEEF);
    check("coll_rf",   dout_rf[31:16], 16'hFFFF);
    check("p1_only",   {30'd0, vld_wf}, 32'h2);
    check("p0_hold",   dout_wf[15:0], 16'hFF34);
    wr(1'b1, 9'd3, 2'b10, 16'h1200);
    tick();
    check("coll_part_wf", dout_wf[31:16], 16'h12EF);
    check("coll_part_rf", dout_rf[31:16], 16'hBEEF);

    // Out-of-range read and write (300 aliases 44 if truncated).
    wr(1'b0, 9'd0, 2'b00, 16'h0);
    rd(2'b01, 9'd0, 9'd300);
    tick();
    check("oor_rd",  dout_wf[15:0], CV);
    check("oor_vld", {30'd0, vld_wf}, 32'h1);
    wr(1'b1, 9'd300, 2'b11, 16'h7777);
    rd(2'b00, 9'd0, 9'd0);
    tick();
    wr(1'b0, 9'd0, 2'b00, 16'h0);
    rd(2'b11, 9'd300, 9'd44);
    tick();
    check("oor_wr_alias", dout_wf, {CV, CV});
    rd(2'b00, 9'd0, 9'd0);
    tick();
    check("idle_vld",  {28'd0, vld_wf, vld_rf}, 32'h0);
    check("idle_hold", dout_wf, {CV, CV});

    // Fill, then clear with colliding traffic on the request edge.
    for (int a = 0; a < 256; a++) begin
      wr(1'b1, 9'(a), 2'b11, 16'h5555);
      tick();
    end
    wr(1'b0, 9'd0, 2'b00, 16'h0);
    rd(2'b11, 9'd5, 9'd5);
    tick();
    check("fill_rd", dout_wf, 32'h5555_5555);
    clr = 1'b1;
    wr(1'b1, 9'd5, 2'b11, 16'h1111);
    rd(2'b11, 9'd6, 9'd5);
    tick();
    clr = 1'b0;
    wr(1'b0, 9'd0, 2'b00, 16'h0);
    check("clr_busy", {30'd0, busy_wf, busy_rf}, 32'h3);
    check("clr_vld",  {30'd0, vld_wf}, 32'h0);
    check("clr_hold", dout_wf, 32'h5555_5555);
    count_busy("clr_len", 1'b1);
    cnt = 0;
    for (int a = 0; a < 256; a += 2) begin
      rd(2'b11, 9'(a + 1), 9'(a));
      tick();
      if (dout_wf !== {CV, CV} || dout_rf !== {CV, CV}) cnt++;
    end
    check("clr_all_words", cnt, 0);

    // Async reset in the middle of a sweep.
    rd(2'b00, 9'd0, 9'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (100) tick();
    check("mid_busy", {31'd0, busy_wf}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_dout", dout_wf | dout_rf, 32'h0);
    check("mid_rst_busy", {30'd0, busy_wf, busy_rf}, 32'h3);
    @(negedge clk);
    rst = 1'b0;
    count_busy("mid_len", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_multi_read_port_clr.md
# ram_multi_read_port_clr

Parametrised multi-read-port synchronous RAM, successor to the team's single/dual-read-port RAMs. Adds N independent read ports, byte-lane write enables, selectable read-during-write behaviour, per-port read-valid flags, and a hardware clear engine that sweeps every word to a fixed value after reset or on request. It serves as the frame/line buffer and register-file store in the VGA and datapath experiments.

## Interface
- DATA_WIDTH, 16, word width; must be a multiple of LANE_WIDTH
- LANE_WIDTH, 8, bits per write-enable lane; LANES = DATA_WIDTH/LANE_WIDTH
- ADDR_WIDTH, 8, address width of every port
- MEM_SIZE, 256, number of words, addresses 0..MEM_SIZE-1; MEM_SIZE <= 2^ADDR_WIDTH
- READ_PORTS, 2, number of independent read ports (>= 1)
- WRITE_FIRST, 1, 1 = same-address read returns newly written data; 0 = returns old data
- CLEAR_VALUE, 0, value written to every word by the clear engine
- Clock  in  1  single system clock, all logic on rising edge
- Reset  in  1  asynchronous, active-high reset
- iClear  in  1  request a full memory clear (sampled on Clock)
- oBusy  out  1  high while the clear engine owns the memory
- iWriteEnable  in  1  write request
- iWriteAddress  in  ADDR_WIDTH  write address
- iByteEnable  in  LANES  per-lane write enable; lane k = bits [k*LANE_WIDTH +: LANE_WIDTH]
- iDataIn  in  DATA_WIDTH  write data
- iReadEnable  in  READ_PORTS  per-port read request
- iReadAddress  in  READ_PORTS*ADDR_WIDTH  port p address at [p*ADDR_WIDTH +: ADDR_WIDTH]
- oDataOut  out  READ_PORTS*DATA_WIDTH  port p data at [p*DATA_WIDTH +: DATA_WIDTH]
- oDataValid  out  READ_PORTS  port p data updated by the read accepted on the previous edge

## Operation
- FSM states: CLEAR, READY. Clear counter ClrAddr, ADDR_WIDTH+1 bits wide.
- Reset asserted (any time, async): state = CLEAR, ClrAddr = 0, oBusy = 1, oDataOut = 0, oDataValid = 0. Array contents are not reset directly; the sweep clears them.
- CLEAR: each edge writes CLEAR_VALUE to Ram[ClrAddr], ClrAddr increments. On the edge writing MEM_SIZE-1: state -> READY, oBusy -> 0.
- READY + iClear = 1: state -> CLEAR, ClrAddr = 0, oBusy -> 1 on that edge; user write on that same edge is dropped.
- CLEAR + iClear = 1: ClrAddr restarts at 0.
- While oBusy = 1 (state CLEAR): user writes ignored, reads ignored, oDataValid = 0, oDataOut holds.
- Write (READY, iWriteEnable = 1, address < MEM_SIZE): only lanes with iByteEnable[k] = 1 updated; others keep old contents. iByteEnable = 0 is a no-op.
- Out-of-range address (>= MEM_SIZE): write dropped with no side effect; read returns CLEAR_VALUE with valid asserted.
- Read port p (READY, iReadEnable[p] = 1): oDataOut[p] <= Ram[addr]; oDataValid[p] <= 1. iReadEnable[p] = 0: oDataOut[p] holds, oDataValid[p] <= 0.
- Read/write collision, same address, same edge: WRITE_FIRST = 1 returns merged word (enabled lanes from iDataIn, rest old). WRITE_FIRST = 0 returns pre-write word. Multiple ports reading one address all get the same value.

## Timing
- Read latency 1 cycle: address sampled on edge N, data/valid visible after edge N, stable until edge N+1.
- Write latency 1 cycle: data written on edge N is returned by a non-colliding read sampled on edge N+1.
- After Reset deasserts, oBusy falls after exactly MEM_SIZE rising edges. First accepted access is on edge MEM_SIZE+1.
- iClear in READY: oBusy high for MEM_SIZE cycles starting the edge after iClear is sampled.
- Ports are fully independent; no arbitration stalls; throughput 1 write + READ_PORTS reads per cycle.

## Test plan
- Reset, MEM_SIZE=256, CLEAR_VALUE=16'hA5A5 -> oBusy high exactly 256 edges; then reads of addr 0, 128 and 255 on both ports return 16'hA5A5 with valid = 1.
- Write 16'h1234 to addr 7, iByteEnable=2'b01, over word 16'hFFFF -> read addr 7 after 1 cycle returns 16'hFF34.
- WRITE_FIRST=1: write 16'hBEEF to addr 3 while port 1 reads addr 3 on the same edge -> oDataOut[1] = 16'hBEEF. Same with WRITE_FIRST=0 -> old value.
- iReadEnable=2'b10 for one cycle -> only oDataValid[1] pulses, oDataOut[0] holds. Read of addr 300 with ADDR_WIDTH=9 -> returns CLEAR_VALUE, valid = 1. Write to addr 300 -> no word changes.
- iClear after filling memory with 16'h5555, plus a write and reads on the same edge -> write dropped, valid = 0 for 256 cycles, then all words equal CLEAR_VALUE.
- Reset asserted mid-sweep at ClrAddr=100 -> outputs zero immediately, sweep restarts, oBusy low 256 edges after release.
